tdc_spi_arbiter: RTL and testbench

//  Shares one byte-wide SPI master between NUM_REQ TDC requesters (measurement sequencers, config loader).

---
 rtl/tdc_pkg.sv | 12 +
 rtl/tdc_spi_arbiter_rr_pick.sv | 32 +++
 rtl/tdc_spi_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_tdc_spi_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC SPI arbitration slice.
package tdc_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam int unsigned TDC_BYTE_W  = 8;
    localparam int unsigned NUM_REQ_MAX = 4;

endpackage

// File: rtl/tdc_spi_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending slot at or after rr_ptr,
// wrapping around to the lowest index.
module rr_pick
    import tdc_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [1:0]         rr_ptr,
    output logic [1:0]         grant,
    output logic               valid
);

    // Two passes: slots at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && pend[i] && (2'(i) >= rr_ptr)) begin
                valid = 1'b1;
                grant = 2'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && pend[i]) begin
                valid = 1'b1;
                grant = 2'(i);
            end
        end
    end

endmodule

// File: rtl/tdc_spi_arbiter.sv
// Shares one byte-wide SPI master between NUM_REQ requesters: one queued byte
// per requester, round-robin ownership, bus locked to the owner for a CS frame.
module tdc_spi_arbiter
    import tdc_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_start,
    input  logic [TDC_BYTE_W*NUM_REQ-1:0] req_mosi,
    input  logic [NUM_REQ-1:0]            req_cs_end,
    output logic [NUM_REQ-1:0]            req_busy,
    output logic [TDC_BYTE_W-1:0]         req_miso,
    output logic [NUM_REQ-1:0]            req_miso_valid,
    output logic                          spi_start,
    output logic [TDC_BYTE_W-1:0]         spi_mosi,
    output logic                          spi_cs_end,
    input  logic                          spi_busy,
    input  logic                          spi_new_data,
    input  logic [TDC_BYTE_W-1:0]         spi_miso,
    output logic [1:0]                    owner,
    output logic                          locked,
    output logic                          err_overrun,
    output logic                          err_timeout
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("tdc_spi_arbiter: NUM_REQ out of range");
    end

    arb_state_t            state, state_nxt;
    logic [NUM_REQ-1:0]    pend;
    logic [NUM_REQ-1:0]    cse_q;
    logic [TDC_BYTE_W-1:0] byte_q [NUM_REQ];
    logic [NUM_REQ-1:0]    pick_pend;
    logic [1:0]            rr_ptr;
    logic [1:0]            grant;
    logic [1:0]            owner_next;
    logic                  grant_valid;
    logic [TDC_BYTE_W-1:0] grant_byte;
    logic                  grant_cse;
    logic                  do_pick, do_done, do_tmo;
    logic [CNT_W-1:0]      cnt;

    // A requester is busy while its byte is queued or currently on the wire.
    always_comb begin
        req_busy = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_busy[i] = pend[i] | ((state == ARB_WAIT) && (owner == 2'(i)));
        end
    end

    // While a frame is open only the owner's slot may be picked.
    always_comb begin
        pick_pend = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pick_pend[i] = pend[i] & (!locked | (owner == 2'(i)));
        end
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .pend   (pick_pend),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .valid  (grant_valid)
    );

    // Fetch the granted slot's byte and frame flag.
    always_comb begin
        grant_byte = '0;
        grant_cse  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == 2'(i)) begin
                grant_byte = byte_q[i];
                grant_cse  = cse_q[i];
            end
        end
    end

    // Round-robin successor of the current owner.
    always_comb begin
        owner_next = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
    end

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        do_pick   = 1'b0;
        do_done   = 1'b0;
        do_tmo    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid && !spi_busy) begin
                    do_pick   = 1'b1;
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (spi_new_data) begin
                    do_done   = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (cnt == CNT_LAST) begin
                    do_tmo    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    // Slots, SPI handshake, lock/pointer bookkeeping and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend           <= '0;
            cse_q          <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) byte_q[i] <= '0;
            rr_ptr         <= '0;
            owner          <= '0;
            locked         <= 1'b0;
            cnt            <= '0;
            spi_start      <= 1'b0;
            spi_mosi       <= '0;
            spi_cs_end     <= 1'b0;
            req_miso       <= '0;
            req_miso_valid <= '0;
            err_overrun    <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            spi_start      <= do_pick;
            req_miso_valid <= '0;
            // A granted slot always has its busy flag set, so a clear and a
            // fresh load can never target the same slot in one cycle.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (do_pick && (grant == 2'(i))) pend[i] <= 1'b0;
                if (req_start[i]) begin
                    if (req_busy[i]) begin
                        err_overrun <= 1'b1;
                    end else begin
                        pend[i]   <= 1'b1;
                        byte_q[i] <= req_mosi[TDC_BYTE_W*i +: TDC_BYTE_W];
                        cse_q[i]  <= req_cs_end[i];
                    end
                end
            end
            if (do_pick) begin
                spi_mosi   <= grant_byte;
                spi_cs_end <= grant_cse;
                owner      <= grant;
                cnt        <= '0;
            end else if (state == ARB_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (do_done) begin
                req_miso <= spi_miso;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (owner == 2'(i)) req_miso_valid[i] <= 1'b1;
                end
                if (spi_cs_end) begin
                    locked <= 1'b0;
                    rr_ptr <= owner_next;
                end else begin
                    locked <= 1'b1;
                end
            end
            if (do_tmo) begin
                err_timeout <= 1'b1;
                locked      <= 1'b0;
                rr_ptr      <= owner_next;
            end
        end
    end

endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// Directed bench for tdc_spi_arbiter: transaction-level scoreboard of expected
// SPI bytes plus per-cycle status expectations, and literal spot checks.
module tb_tdc_spi_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_start = '0;
    logic [8*NR-1:0]   req_mosi = '0;
    logic [NR-1:0]     req_cs_end = '0;
    logic [NR-1:0]     req_busy;
    logic [7:0]        req_miso;
    logic [NR-1:0]     req_miso_valid;
    logic              spi_start;
    logic [7:0]        spi_mosi;
    logic              spi_cs_end;
    logic              spi_busy = 1'b0;
    logic              spi_new_data = 1'b0;
    logic [7:0]        spi_miso = '0;
    logic [1:0]        owner;
    logic              locked;
    logic              err_overrun;
    logic              err_timeout;

    tdc_spi_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_start      (req_start),
        .req_mosi       (req_mosi),
        .req_cs_end     (req_cs_end),
        .req_busy       (req_busy),
        .req_miso       (req_miso),
        .req_miso_valid (req_miso_valid),
        .spi_start      (spi_start),
        .spi_mosi       (spi_mosi),
        .spi_cs_end     (spi_cs_end),
        .spi_busy       (spi_busy),
        .spi_new_data   (spi_new_data),
        .spi_miso       (spi_miso),
        .owner          (owner),
        .locked         (locked),
        .err_overrun    (err_overrun),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The SPI slave answers every byte with this fixed transform.
    function automatic logic [7:0] resp(input logic [7:0] b);
        return b ^ 8'h56;
    endfunction

    // SPI master model: busy for spi_delay cycles, then new_data unless muted.
    int         spi_delay = 10;
    bit         spi_mute  = 1'b0;
    int         rem       = 0;
    logic [7:0] lat       = '0;
    always @(posedge clk) begin
        #1;
        spi_new_data = 1'b0;
        if (rst) begin
            spi_busy = 1'b0;
            rem      = 0;
        end else if (spi_start) begin
            spi_busy = 1'b1;
            rem      = spi_delay;
            lat      = spi_mosi;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                spi_busy = 1'b0;
                if (!spi_mute) begin
                    spi_new_data = 1'b1;
                    spi_miso     = resp(lat);
                end
            end
        end
    end

    // Scoreboard state: expected byte order, accepted-request count per requester.
    typedef struct packed {
        logic [1:0] o;
        logic [7:0] b;
        logic       c;
    } exp_t;

    exp_t          expq[$];
    exp_t          cur;
    bit            infl, nd_prev, exp_ovr, exp_tmo, exp_lock, prev_busy;
    int            elapsed;
    int            outst [NR];
    logic [NR-1:0] exp_v;

    function automatic bit idle_now();
        bit r = (expq.size() == 0) && !infl && !nd_prev;
        for (int i = 0; i < NR; i++) if (outst[i] != 0) r = 1'b0;
        return r;
    endfunction

    // Per-cycle comparison against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            infl = 0; nd_prev = 0; exp_ovr = 0; exp_tmo = 0; exp_lock = 0;
            elapsed = 0;
            for (int i = 0; i < NR; i++) outst[i] = 0;
            prev_busy = spi_busy;
        end else begin
            exp_v = '0;
            if (nd_prev) begin
                exp_v = NR'(1) << cur.o;
                if (outst[int'(cur.o)] > 0) outst[int'(cur.o)]--;
                exp_lock = !cur.c;
            end
            chk("miso_valid", 32'(req_miso_valid), 32'(exp_v));
            if (nd_prev) begin
                chk("miso_byte", 32'(req_miso), 32'(resp(cur.b)));
                chk("idle_gap", 32'(spi_start), 32'd0);
            end
            nd_prev = 0;
            if (infl && elapsed >= TMO) begin
                infl = 0;
                if (outst[int'(cur.o)] > 0) outst[int'(cur.o)]--;
                exp_tmo  = 1;
                exp_lock = 0;
            end
            if (spi_start) begin
                chk("start_while_inflight", 32'(infl), 32'd0);
                chk("start_while_spi_busy", 32'(prev_busy), 32'd0);
                chk("start_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    cur = expq.pop_front();
                    chk("start_mosi", 32'(spi_mosi), 32'(cur.b));
                    chk("start_cs_end", 32'(spi_cs_end), 32'(cur.c));
                    chk("start_owner", 32'(owner), 32'(cur.o));
                end
                infl    = 1;
                elapsed = 0;
            end else if (infl) begin
                chk("mosi_stable", 32'(spi_mosi), 32'(cur.b));
                chk("cs_end_stable", 32'(spi_cs_end), 32'(cur.c));
            end
            if (infl && spi_new_data) begin
                nd_prev = 1;
                infl    = 0;
            end
            if (infl) elapsed++;
            chk("locked", 32'(locked), 32'(exp_lock));
            chk("err_timeout", 32'(err_timeout), 32'(exp_tmo));
            chk("err_overrun", 32'(err_overrun), 32'(exp_ovr));
            for (int i = 0; i < NR; i++)
                chk("req_busy", 32'(req_busy[i]), 32'(outst[i] > 0));
            for (int i = 0; i < NR; i++) begin
                if (req_start[i]) begin
                    if (outst[i] > 0) exp_ovr = 1;
                    else              outst[i] = 1;
                end
            end
            prev_busy = spi_busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i, input logic [7:0] b, input logic c);
        req_start[i]       = 1'b1;
        req_mosi[8*i +: 8] = b;
        req_cs_end[i]      = c;
        step();
        req_start = '0;
    endtask

    task automatic push(input logic [1:0] o, input logic [7:0] b, input logic c);
        exp_t e;
        e.o = o; e.b = b; e.c = c;
        expq.push_back(e);
    endtask

    // Returns at the negedge of the spi_start cycle.
    task automatic wait_start(input int maxc, output int at);
        bit found = 0;
        at = 0;
        for (int n = 0; n < maxc && !found; n++) begin
            @(negedge clk);
            if (spi_start) begin found = 1; at = cyc; end
        end
        chk("wait_start_bound", 32'(found), 32'd1);
    endtask

    // Returns at the negedge of the cycle where req_miso_valid[i] pulses.
    task automatic wait_valid(input int i, input int maxc);
        bit found = 0;
        for (int n = 0; n < maxc && !found; n++) begin
            @(negedge clk);
            if (req_miso_valid[i]) found = 1;
        end
        chk("wait_valid_bound", 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (!idle_now() && n < maxc) begin
            step();
            n++;
        end
        chk("drain_bound", 32'(n < maxc), 32'd1);
        step();
        step();
    endtask

    initial begin
        int s, d, n;
        // Reset state
        step(); step();
        @(negedge clk);
        chk("reset_outputs", 32'({req_busy, req_miso, req_miso_valid, spi_start, spi_mosi,
                                  spi_cs_end, owner, locked, err_overrun, err_timeout}), 32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: single byte, latency t+2, reply 0x5C, frame closed
        push(2'd0, 8'h0A, 1'b1);
        req_start[0] = 1'b1; req_mosi[7:0] = 8'h0A; req_cs_end[0] = 1'b1;
        step();
        req_start = '0;
        @(negedge clk);
        chk("t1_no_start_t1", 32'(spi_start), 32'd0);
        step();
        @(negedge clk);
        chk("t1_start_t2", 32'(spi_start), 32'd1);
        chk("t1_mosi", 32'(spi_mosi), 32'h0A);
        wait_valid(0, 30);
        chk("t1_miso", 32'(req_miso), 32'h5C);
        chk("t1_locked", 32'(locked), 32'd0);
        step();
        wait_idle(100);

        // 3: collision with rr_ptr=1 -> requester 1 first
        push(2'd1, 8'hB1, 1'b1);
        push(2'd0, 8'hA0, 1'b1);
        req_start = 2'b11; req_mosi = {8'hB1, 8'hA0}; req_cs_end = 2'b11;
        step();
        req_start = '0;
        wait_start(10, s);
        chk("t3_first_owner", 32'(owner), 32'd1);
        step();
        wait_idle(200);

        // 2: locked frame keeps requester 1 waiting across an owner pause
        push(2'd0, 8'h20, 1'b0);
        push(2'd0, 8'h21, 1'b1);
        push(2'd1, 8'h99, 1'b1);
        pulse(0, 8'h20, 1'b0);
        wait_start(10, s);
        step();
        pulse(1, 8'h99, 1'b1);
        wait_valid(0, 30);
        chk("t2_locked_mid", 32'(locked), 32'd1);
        step();
        for (int k = 0; k < 5; k++) step();
        @(negedge clk);
        chk("t2_busy1_waiting", 32'(req_busy[1]), 32'd1);
        chk("t2_no_preempt", 32'(spi_start), 32'd0);
        step();
        pulse(0, 8'h21, 1'b1);
        wait_idle(200);

        // 4: overrun, second pulse dropped
        push(2'd0, 8'h33, 1'b1);
        req_start[0] = 1'b1; req_mosi[7:0] = 8'h33; req_cs_end[0] = 1'b1;
        step();
        req_mosi[7:0] = 8'h44;
        step();
        req_start = '0;
        wait_idle(100);
        @(negedge clk);
        chk("t4_overrun", 32'(err_overrun), 32'd1);
        step();

        // 5: timeout at spi_start+50, lock dropped, pending requester served
        spi_delay = 8;
        spi_mute  = 1'b1;
        push(2'd0, 8'h55, 1'b0);
        push(2'd1, 8'h66, 1'b1);
        pulse(0, 8'h55, 1'b0);
        pulse(1, 8'h66, 1'b1);
        wait_start(10, s);
        d = -1;
        for (int k = 0; k < 100 && d < 0; k++) begin
            @(negedge clk);
            if (err_timeout) d = cyc - s;
        end
        chk("t5_timeout_latency", 32'(d), 32'd50);
        chk("t5_locked", 32'(locked), 32'd0);
        spi_mute  = 1'b0;
        spi_delay = 10;
        step();
        wait_idle(200);

        // 6: reset mid-byte with both requesters loaded
        push(2'd0, 8'h11, 1'b1);
        req_start = 2'b11; req_mosi = {8'h22, 8'h11}; req_cs_end = 2'b11;
        step();
        req_start = '0;
        wait_start(10, s);
        step(); step(); step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t6_reset_outputs", 32'({req_busy, req_miso, req_miso_valid, spi_start, spi_mosi,
                                     spi_cs_end, owner, locked, err_overrun, err_timeout}), 32'd0);
        step();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (spi_start) n++;
        end
        chk("t6_no_start_after_reset", 32'(n), 32'd0);
        step();
        push(2'd0, 8'h7E, 1'b1);
        pulse(0, 8'h7E, 1'b1);
        wait_valid(0, 30);
        chk("t6_fresh_miso", 32'(req_miso), 32'h28);
        step();
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got still running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
